inbuf_feed_ctrl: RTL and testbench
==================================

Name: inbuf_feed_ctrl

Overview:
- Sequences the NROWS row input buffers (circular FIFOs, row r built with PADDING=r) that feed the systolic PE array.
- Per tile: clears the row buffers to re-establish their skew padding, then steers a single loader stream into the rows in row-major order.
- Then issues lock-step read strobes and the array enable for the skewed drain, and reports completion.

Parameters:
NROWS, 4, number of row buffers / PE array rows
WORDLEN, 8, data word width
MAXLEN, 16, max tile length K; row buffer depth must be >= MAXLEN+NROWS-1
CNTW, 5, counter/config width; 2^CNTW > MAXLEN+NROWS-1 and 2^CNTW > MAXLEN

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin tile; honoured only in IDLE
cfg_len  in  CNTW  tile length K, sampled on accepted start
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at tile end
err  out  1  one-cycle pulse on bad config or drain mismatch
in_valid  in  1  loader word valid
in_ready  out  1  controller accepts loader word
in_data  in  WORDLEN  loader word
buf_clr_n  out  1  active-low synchronous clear to all row buffers
buf_wr  out  NROWS  one-hot write strobe to row buffers
buf_din  out  WORDLEN  write data, broadcast to all rows
buf_rd  out  NROWS  read strobes, all bits equal
buf_empty  in  NROWS  empty flags from row buffers
arr_stall  in  1  PE array back-pressure
arr_en  out  1  PE array advance enable

Behaviour:
- Reset values: busy/done/err/in_ready/buf_wr/buf_rd/arr_en = 0.
- buf_clr_n is 0 while rst is high, so the buffers are held cleared. It goes to 1 on the first clk edge after rst deasserts.
- rst mid-tile aborts immediately to IDLE. Counters and latched length are zeroed.
- States: IDLE, CLEAR, LOAD, RUN, FIN.
- IDLE:
  - start with 1 <= cfg_len <= MAXLEN: latch len=cfg_len, go to CLEAR.
  - start with cfg_len=0 or > MAXLEN: err pulse next cycle, stay IDLE.
- CLEAR:
  - Exactly one cycle with buf_clr_n=0 (registered), then go to LOAD.
  - Row pointer and column counter cleared to 0.
- LOAD:
  - in_ready=1.
  - Accept = in_valid && in_ready.
  - buf_wr[row_ptr] = accept (combinational). buf_din = in_data (combinational).
  - Per accept, col increments. At col == len-1, col wraps to 0 and row_ptr increments.
  - Accept with row_ptr == NROWS-1 and col == len-1 is the last word: go to RUN next cycle. in_ready drops the same edge.
  - in_valid low: no write, counters hold.
- RUN:
  - Drain counter target = len+NROWS-1.
  - Each cycle with arr_stall=0: buf_rd = all ones, arr_en=1, counter increments.
  - Each cycle with arr_stall=1: buf_rd=0, arr_en=0, counter holds.
  - Shorter rows empty before the drain ends and supply 0s. The controller does not gate per row.
  - After the last unstalled read cycle, go to FIN.
- FIN:
  - One cycle: done=1, then go to IDLE.
  - If any buf_empty bit is 0 in FIN, err=1 in the same cycle as done.
- start outside IDLE is ignored; cfg_len changes outside IDLE are ignored.
- Total latency with no stalls or gaps: 1 (CLEAR) + NROWS*len (LOAD) + len+NROWS-1 (RUN) + 1 (FIN) cycles after the start cycle.

Test Plan:
1. Nominal (NROWS=4): rst, then start with cfg_len=3 and in_valid held high, words 0x01..0x0C.
   - buf_clr_n low 1 cycle.
   - buf_wr=0001 for 0x01-0x03, 0010 for 0x04-0x06, 0100 for 0x07-0x09, 1000 for 0x0A-0x0C.
   - RUN 6 cycles with buf_rd=1111, then done pulse; busy low the following cycle.
2. Loader gaps: cfg_len=3, in_valid toggles every cycle.
   - LOAD lasts 24 cycles, 12 writes total, buf_wr=0000 whenever in_valid=0.
3. Stall: cfg_len=2, arr_stall high for 2 cycles mid-RUN.
   - RUN spans 7 cycles, exactly 5 buf_rd/arr_en cycles, done after the 5th.
4. Bad config: start with cfg_len=0, then with cfg_len=17.
   - Each gives an err pulse; busy stays 0, buf_clr_n stays 1, no writes.
5. Abort: assert rst during LOAD after 5 accepted words.
   - All outputs 0 asynchronously; buf_clr_n=0 until the first edge after release.
   - A following start with cfg_len=1 completes normally in 1+4+4+1 cycles.
6. Drain mismatch: force buf_empty[2]=0 during FIN.
   - err and done pulse in the same cycle.
   - A start issued together with the ignored-while-busy check does not restart the tile.

Source files
------------

// File: rtl/inbuf_feed_ctrl.sv
// Row input buffer feed controller for the systolic PE array.
// Per tile: clear the row buffers so they re-establish their skew padding,
// steer one loader stream into the rows in row-major order, then drain all
// rows in lock-step while the array advances, and report completion.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | waiting for start; bad cfg_len gives an err pulse
//  CLEAR | one cycle of buf_clr_n=0, row/col pointers reset
//  LOAD  | accept len words per row into rows 0..NROWS-1
//  RUN   | lock-step drain of len+NROWS-1 unstalled read cycles
//  FIN   | done pulse; err if any row buffer is not empty
module inbuf_feed_ctrl #(
    parameter int NROWS   = 4,
    parameter int WORDLEN = 8,
    parameter int MAXLEN  = 16,
    parameter int CNTW    = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [CNTW-1:0]    cfg_len_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [WORDLEN-1:0] in_data_i,
    output logic               buf_clr_n_o,
    output logic [NROWS-1:0]   buf_wr_o,
    output logic [WORDLEN-1:0] buf_din_o,
    output logic [NROWS-1:0]   buf_rd_o,
    input  logic [NROWS-1:0]   buf_empty_i,
    input  logic               arr_stall_i,
    output logic               arr_en_o
);

    localparam int              RW         = (NROWS > 1) ? $clog2(NROWS) : 1;
    localparam logic [CNTW-1:0] MAXLEN_C   = CNTW'(MAXLEN);
    localparam logic [CNTW-1:0] SKEW_C     = CNTW'(NROWS - 1);
    localparam logic [RW-1:0]   LAST_ROW_C = RW'(NROWS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        LOAD  = 3'd2,
        RUN   = 3'd3,
        FIN   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CNTW-1:0] len_q, len_d;
    logic [CNTW-1:0] col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    // Drain timer counts down the remaining unstalled read cycles.
    logic [CNTW-1:0] drain_q, drain_d;
    logic            err_cfg_q, err_cfg_d;
    logic            clr_n_q;

    // State, counters and registered flags; reset aborts any tile in progress.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            len_q     <= '0;
            col_q     <= '0;
            row_q     <= '0;
            drain_q   <= '0;
            err_cfg_q <= 1'b0;
            clr_n_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            col_q     <= col_d;
            row_q     <= row_d;
            drain_q   <= drain_d;
            err_cfg_q <= err_cfg_d;
            // Clear is registered so the buffers see a clean one-cycle pulse.
            clr_n_q   <= (state_d != CLEAR);
        end
    end

    // Next-state logic plus the per-state strobes toward loader, buffers and array.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        col_d      = col_q;
        row_d      = row_q;
        drain_d    = drain_q;
        err_cfg_d  = 1'b0;
        in_ready_o = 1'b0;
        buf_wr_o   = '0;
        buf_rd_o   = '0;
        arr_en_o   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if ((cfg_len_i != '0) && (cfg_len_i <= MAXLEN_C)) begin
                        len_d   = cfg_len_i;
                        state_d = CLEAR;
                    end else begin
                        err_cfg_d = 1'b1;
                    end
                end
            end

            CLEAR: begin
                col_d   = '0;
                row_d   = '0;
                state_d = LOAD;
            end

            LOAD: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    buf_wr_o[row_q] = 1'b1;
                    if (col_q == len_q - 1'b1) begin
                        col_d = '0;
                        if (row_q == LAST_ROW_C) begin
                            drain_d = len_q + SKEW_C;
                            state_d = RUN;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end

            RUN: begin
                // Rows that run dry early return zeros; no per-row gating here.
                if (!arr_stall_i) begin
                    buf_rd_o = '1;
                    arr_en_o = 1'b1;
                    drain_d  = drain_q - 1'b1;
                    if (drain_q == CNTW'(1)) begin
                        state_d = FIN;
                    end
                end
            end

            FIN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == FIN);
    assign err_o       = err_cfg_q | ((state_q == FIN) && (buf_empty_i != '1));
    assign buf_clr_n_o = clr_n_q;
    assign buf_din_o   = in_data_i;

endmodule

// File: tb/tb_inbuf_feed_ctrl.sv
// Bench for inbuf_feed_ctrl: a table of tile scenarios with hand-derived
// outcome counts, a per-cycle timeline model built from the stimulus
// patterns, randomized tiles, and hand-written reset/abort sequences.
module tb_inbuf_feed_ctrl;

    localparam int NROWS   = 4;
    localparam int WORDLEN = 8;
    localparam int MAXLEN  = 16;
    localparam int CNTW    = 5;
    localparam int CYC     = 400;

    logic               clk;
    logic               rst;
    logic               start;
    logic [CNTW-1:0]    cfg_len;
    logic               busy;
    logic               done;
    logic               err;
    logic               in_valid;
    logic               in_ready;
    logic [WORDLEN-1:0] in_data;
    logic               buf_clr_n;
    logic [NROWS-1:0]   buf_wr;
    logic [WORDLEN-1:0] buf_din;
    logic [NROWS-1:0]   buf_rd;
    logic [NROWS-1:0]   buf_empty;
    logic               arr_stall;
    logic               arr_en;

    int vectors     = 0;
    int miscompares = 0;

    inbuf_feed_ctrl #(
        .NROWS(NROWS), .WORDLEN(WORDLEN), .MAXLEN(MAXLEN), .CNTW(CNTW)
    ) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .cfg_len_i(cfg_len),
        .busy_o(busy), .done_o(done), .err_o(err),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .buf_clr_n_o(buf_clr_n), .buf_wr_o(buf_wr), .buf_din_o(buf_din),
        .buf_rd_o(buf_rd), .buf_empty_i(buf_empty),
        .arr_stall_i(arr_stall), .arr_en_o(arr_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-cycle stimulus patterns; cycle 0 is the start cycle.
    logic               start_pat [CYC];
    logic [CNTW-1:0]    cfg_pat   [CYC];
    logic               valid_pat [CYC];
    logic               stall_pat [CYC];
    logic [NROWS-1:0]   empty_pat [CYC];
    logic [WORDLEN-1:0] data_pat  [CYC];

    typedef struct {
        int len;
        int vmode;      // 0: valid always, 1: valid on odd cycles, 2: random
        int sfrom;      // stall window, absolute cycles
        int sto;
        int mis;        // drive a non-empty row during the tile
        int fin_start;  // extra start pulse in the FIN cycle
        int exp_done;   // cycle of done pulse, -1 if none
        int exp_wr;
        int exp_rd;
        int exp_err;    // cycle of err pulse, -1 if none
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        start     = 1'b0;
        cfg_len   = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        arr_stall = 1'b0;
        buf_empty = '1;
    endtask

    // Builds the stimulus, derives the expected timeline from the rules
    // (clear, NROWS*len accepted words, len+NROWS-1 unstalled reads, fin),
    // drives it and compares every cycle.
    task automatic run_tile(input int len, input int vmode, input int sfrom, input int sto,
                            input int mis, input int fin_start, input int rnd,
                            output int o_done, output int o_wr, output int o_rd, output int o_err);
        int c, c_l, c_r, c_fin, end_c, words, reads, widx;
        bit bad;
        logic e_busy, e_clr, e_rdy, e_done, e_err, e_en;
        logic [NROWS-1:0] e_wr, e_rd;

        bad = (len < 1) || (len > MAXLEN);
        for (int i = 0; i < CYC; i++) begin
            start_pat[i] = (i == 0) || ((rnd != 0) && ($urandom_range(0, 4) == 0));
            cfg_pat[i]   = (i == 0) ? CNTW'(len) : CNTW'($urandom_range(1, 31));
            case (vmode)
                0:       valid_pat[i] = 1'b1;
                1:       valid_pat[i] = (i % 2 == 1);
                default: valid_pat[i] = (i >= 200) || ($urandom_range(0, 9) < 7);
            endcase
            stall_pat[i] = (rnd != 0) ? ((i < 200) && ($urandom_range(0, 3) == 0))
                                      : ((i >= sfrom) && (i <= sto));
            if (mis != 0)
                empty_pat[i] = 4'b1011;
            else if ((rnd != 0) && ($urandom_range(0, 5) == 0))
                empty_pat[i] = 4'($urandom_range(0, 14));
            else
                empty_pat[i] = 4'hF;
            data_pat[i] = 8'($urandom);
        end

        c_l = 0; c_r = 0; c_fin = 0;
        if (!bad) begin
            words = 0;
            c = 1;
            while ((words < NROWS * len) && (c < CYC - 8)) begin
                c++;
                if (valid_pat[c]) words++;
            end
            c_l = c;
            reads = 0;
            while ((reads < len + NROWS - 1) && (c < CYC - 4)) begin
                c++;
                if (!stall_pat[c]) reads++;
            end
            c_r   = c;
            c_fin = c_r + 1;
            end_c = c_fin + 2;
            for (int i = c_fin + 1; i < CYC; i++) start_pat[i] = 1'b0;
            if (fin_start != 0) begin
                start_pat[c_fin] = 1'b1;
                cfg_pat[c_fin]   = CNTW'(1);
            end
        end else begin
            end_c = 3;
            for (int i = 1; i < CYC; i++) start_pat[i] = 1'b0;
        end

        widx = 0; o_done = -1; o_wr = 0; o_rd = 0; o_err = -1;
        for (int i = 0; i <= end_c; i++) begin
            @(negedge clk);
            start     = start_pat[i];
            cfg_len   = cfg_pat[i];
            in_valid  = valid_pat[i];
            in_data   = data_pat[i];
            arr_stall = stall_pat[i];
            buf_empty = empty_pat[i];
            #1;
            e_busy = !bad && (i >= 1) && (i <= c_fin);
            e_clr  = !(!bad && (i == 1));
            e_rdy  = !bad && (i >= 2) && (i <= c_l);
            e_wr   = '0;
            if (e_rdy && valid_pat[i]) begin
                e_wr[widx / len] = 1'b1;
                widx++;
            end
            e_rd   = (!bad && (i > c_l) && (i <= c_r) && !stall_pat[i]) ? 4'hF : 4'h0;
            e_en   = (e_rd != 4'h0);
            e_done = !bad && (i == c_fin);
            e_err  = bad ? (i == 1) : ((i == c_fin) && (empty_pat[i] != 4'hF));
            vectors++;
            if ((busy !== e_busy) || (buf_clr_n !== e_clr) || (in_ready !== e_rdy) ||
                (buf_wr !== e_wr) || (buf_rd !== e_rd) || (arr_en !== e_en) ||
                (done !== e_done) || (err !== e_err) ||
                ((e_wr != 4'h0) && (buf_din !== data_pat[i]))) begin
                miscompares++;
                $display("FAIL cyc %0d len %0d (got/exp): busy %b/%b clr_n %b/%b rdy %b/%b wr %b/%b rd %b/%b en %b/%b done %b/%b err %b/%b din %h/%h",
                         i, len, busy, e_busy, buf_clr_n, e_clr, in_ready, e_rdy,
                         buf_wr, e_wr, buf_rd, e_rd, arr_en, e_en, done, e_done,
                         err, e_err, buf_din, data_pat[i]);
            end
            if (done === 1'b1) o_done = i;
            if (err === 1'b1) o_err = i;
            if (buf_wr != '0) o_wr++;
            if (arr_en === 1'b1) o_rd++;
        end
        @(negedge clk);
        drive_idle();
    endtask

    initial begin
        int od, ow, orr, oe;

        // len vmode sfrom sto mis fin_start | done wr rd err
        tbl[0] = '{3,  0, 1,  0,  0, 0, 20, 12, 6,  -1};
        tbl[1] = '{3,  1, 1,  0,  0, 0, 32, 12, 6,  -1};
        tbl[2] = '{2,  0, 12, 13, 0, 0, 17, 8,  5,  -1};
        tbl[3] = '{0,  0, 1,  0,  0, 0, -1, 0,  0,  1};
        tbl[4] = '{17, 0, 1,  0,  0, 0, -1, 0,  0,  1};
        tbl[5] = '{4,  0, 1,  0,  1, 1, 25, 16, 7,  25};
        tbl[6] = '{16, 0, 1,  0,  0, 0, 85, 64, 19, -1};
        tbl[7] = '{1,  0, 1,  0,  0, 0, 10, 4,  4,  -1};

        rst = 1'b1;
        drive_idle();
        #2;
        chk("rst clr_n", 32'(buf_clr_n), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst strobes", {22'd0, done, err, in_ready, arr_en, buf_wr, buf_rd}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("clr_n before first edge", 32'(buf_clr_n), 32'd0);
        @(negedge clk);
        #1;
        chk("clr_n after first edge", 32'(buf_clr_n), 32'd1);
        chk("idle busy", 32'(busy), 32'd0);

        for (int t = 0; t < 8; t++) begin
            run_tile(tbl[t].len, tbl[t].vmode, tbl[t].sfrom, tbl[t].sto,
                     tbl[t].mis, tbl[t].fin_start, 0, od, ow, orr, oe);
            vectors++;
            if ((od != tbl[t].exp_done) || (ow != tbl[t].exp_wr) ||
                (orr != tbl[t].exp_rd) || (oe != tbl[t].exp_err)) begin
                miscompares++;
                $display("FAIL tbl%0d (got/exp): done %0d/%0d wr %0d/%0d rd %0d/%0d err %0d/%0d",
                         t, od, tbl[t].exp_done, ow, tbl[t].exp_wr, orr, tbl[t].exp_rd,
                         oe, tbl[t].exp_err);
            end
        end

        // Abort mid-LOAD after five accepted words.
        @(negedge clk);
        start = 1'b1; cfg_len = 5'd3; in_valid = 1'b1; in_data = 8'h01;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            start   = 1'b0;
            in_data = 8'(k + 1);
        end
        #1;
        chk("abort 5th word row", 32'(buf_wr), 32'h2);
        @(negedge clk);
        #1;
        chk("abort pre rdy", 32'(in_ready), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort strobes", {22'd0, done, err, in_ready, arr_en, buf_wr, buf_rd}, 32'd0);
        chk("abort clr_n", 32'(buf_clr_n), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive_idle();
        #1;
        chk("abort clr_n held", 32'(buf_clr_n), 32'd0);
        @(negedge clk);
        #1;
        chk("abort clr_n release", 32'(buf_clr_n), 32'd1);
        run_tile(1, 0, 1, 0, 0, 0, 0, od, ow, orr, oe);
        chk("post-abort done cycle", 32'(od), 32'd10);

        // Randomized tiles against the timeline model.
        for (int t = 0; t < 25; t++) begin
            run_tile(int'($urandom_range(1, MAXLEN)), 2, 1, 0, 0, 0, 1, od, ow, orr, oe);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
